traffic_sense_timer: RTL
========================

Name: traffic_sense_timer

Overview:
- Front-end stage that feeds the traffic-light controller FSM.
- Conditions the raw car-sensor input into a clean, debounced `c`.
- Runs the two interval timers that consume the controller's registered timer-start level `st` and return the long-timeout flag `tl` and short-timeout flag `ts`.
- All outputs are registered. One clock domain.

Parameters:
- CNT_W, 16, width of the interval counter; must hold LONG_CYCLES and SHORT_CYCLES.
- LONG_CYCLES, 1000, clock edges from long-interval start to `tl` assertion; legal range 2..2^CNT_W-1.
- SHORT_CYCLES, 200, clock edges from short-interval start to `ts` assertion; legal range 2..2^CNT_W-1.
- DB_W, 4, width of the debounce counter.
- DB_CYCLES, 8, consecutive synchronized samples needed to accept a new car-sensor level; legal range 1..2^DB_W-1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- car_raw  in  1  raw car-sensor level; asynchronous, may glitch.
- st  in  1  timer-start level from the controller: 1 = short interval, 0 = long interval.
- c  out  1  debounced car-present flag.
- tl  out  1  long interval expired; sticky while in long mode.
- ts  out  1  short interval expired; sticky while in short mode.
- mode  out  1  current timer mode: 0 = long, 1 = short (status/debug).

Behaviour:
- Reset: one clock, synchronous, active-high.
  - While reset is sampled high: c=0, tl=0, ts=0, mode=0; timer state LONG_WAIT; interval counter 0; sync flops 0; debounce counter 0.
  - Reset asserted mid-interval or mid-debounce aborts the operation immediately; nothing is held over.
- Timer FSM states: LONG_WAIT, LONG_DONE, SHORT_WAIT, SHORT_DONE. Registered outputs mode = state is SHORT_*, tl = state is LONG_DONE, ts = state is SHORT_DONE.
- Entry edge: the first edge after reset release, or the edge at which st is first sampled at a value differing from the current mode. On an entry edge:
  - counter <= 1;
  - state <= LONG_WAIT if st=0, SHORT_WAIT if st=1;
  - tl and ts deassert on that same edge.
- LONG_WAIT, st=0: counter increments each edge. On the edge where counter equals LONG_CYCLES-1, state goes to LONG_DONE. Result: tl is first high after exactly LONG_CYCLES edges counted from the entry edge (entry edge = edge 1).
- SHORT_WAIT, st=1: same rule with SHORT_CYCLES; ts is first high after exactly SHORT_CYCLES edges.
- LONG_DONE / SHORT_DONE: counter holds (saturates) and never wraps. The flag stays high until an entry edge or reset.
- st change before expiry: the interval is abandoned and the opposite mode restarts from 1. The abandoned flag never pulses.
- tl and ts are never high simultaneously. A mode switch clears the old flag on the same edge.
- Car-sensor path:
  - car_raw passes through a 2-flop synchronizer, giving car_s.
  - If car_s == c: debounce counter is cleared to 0.
  - Else the debounce counter increments. On the edge where it equals DB_CYCLES-1 with car_s != c: c <= car_s and the counter is cleared.
  - Net latency from a stable car_raw change to c: DB_CYCLES+2 edges.
  - A pulse of fewer than DB_CYCLES synchronized samples never changes c. Any return to the c level clears the count.
- The car path and timer path are independent. Simultaneous st change and car change are each handled per their own rules in the same cycle.
- No combinational path from any input to any output.

Test Plan (LONG_CYCLES=10, SHORT_CYCLES=4, DB_CYCLES=3):
- Reset 3 cycles, then st=0 held -> tl=0 for edges 1..9 after release, tl=1 from edge 10 and held through edge 40; ts=0 and mode=0 throughout.
- From LONG_DONE, raise st -> on the first edge st is sampled 1: tl=0, mode=1; ts=1 exactly 4 edges after that edge; drop st -> ts=0 and mode=0 on the sampling edge; tl=1 again 10 edges later.
- st=1 held for 2 edges then back to 0 -> ts never asserts; tl asserts 10 edges after the fall edge.
- car_raw 0->1 held -> c=1 on edge 5 after the change. car_raw high for 2 cycles then low -> c stays 0. car_raw toggling every cycle for 20 cycles -> c unchanged.
- Assert reset at edge 6 of a long interval with c=1 -> all outputs 0 on that edge; after release, tl at edge 10; c returns to 1 after 5 edges if car_raw is still high.
- st toggled on the same edge that LONG_WAIT would reach LONG_DONE -> mode switch wins: tl stays 0, SHORT_WAIT entered with counter 1.

Source files
------------

// File: rtl/traffic_sense_timer.sv
`default_nettype none
// ============================================================================
// Module      : traffic_sense_timer
// Description : Front end for the traffic-light controller. Debounces the raw
//               car sensor into c and runs the long/short interval timers
//               selected by the controller's timer-start level st, returning
//               the sticky expiry flags tl and ts.
// Ports       : clk     - clock, rising edge
//               reset   - synchronous, active-high reset
//               car_raw - raw, asynchronous car-sensor level
//               st      - timer select: 1 = short interval, 0 = long interval
//               c       - debounced car-present flag
//               tl      - long interval expired (sticky in long mode)
//               ts      - short interval expired (sticky in short mode)
//               mode    - current timer mode, 0 = long, 1 = short
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_sense_timer #(
    parameter int CNT_W        = 16,
    parameter int LONG_CYCLES  = 1000,
    parameter int SHORT_CYCLES = 200,
    parameter int DB_W         = 4,
    parameter int DB_CYCLES    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic car_raw,
    input  logic st,
    output logic c,
    output logic tl,
    output logic ts,
    output logic mode
);

    localparam logic [CNT_W-1:0] c_LONG_LAST  = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_SHORT_LAST = CNT_W'(SHORT_CYCLES - 1);
    localparam logic [DB_W-1:0]  c_DB_LAST    = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LONG_WAIT  = 2'd0,
        S_LONG_DONE  = 2'd1,
        S_SHORT_WAIT = 2'd2,
        S_SHORT_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Interval timer
    // ------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_mode_cur;
    logic             w_entry;

    assign w_mode_cur = (r_state == S_SHORT_WAIT) || (r_state == S_SHORT_DONE);

    // The counter is only ever zero between reset and the first edge after
    // release (entry loads 1 and DONE states saturate), so a zero count marks
    // the pending post-reset entry edge.
    assign w_entry = (r_cnt == '0) || (st != w_mode_cur);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LONG_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_entry) begin
            // Mode switch takes priority over an expiry due on the same edge.
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = st ? S_SHORT_WAIT : S_LONG_WAIT;
        end else begin
            case (r_state)
                S_LONG_WAIT: begin
                    if (r_cnt == c_LONG_LAST) begin
                        w_state_nxt = S_LONG_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                S_SHORT_WAIT: begin
                    if (r_cnt == c_SHORT_LAST) begin
                        w_state_nxt = S_SHORT_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // DONE states: counter saturates, flag held.
                    w_state_nxt = r_state;
                    w_cnt_nxt   = r_cnt;
                end
            endcase
        end
    end

    // Outputs decode the state register only; no input reaches them
    // combinationally.
    assign mode = w_mode_cur;
    assign tl   = (r_state == S_LONG_DONE);
    assign ts   = (r_state == S_SHORT_DONE);

    // ------------------------------------------------------------------------
    // Car-sensor synchronizer and debounce
    // ------------------------------------------------------------------------
    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    logic            r_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_db_cnt <= '0;
            r_c      <= 1'b0;
        end else begin
            r_sync1 <= car_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_c) begin
                // Any return to the accepted level restarts the qualification.
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_c      <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    assign c = r_c;

endmodule
`default_nettype wire
